// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared sizes, sequencer state encoding and error codes for the matrix adder
package matrix_pkg;

   localparam int DIM_MAX = 5;
   localparam int ELEM_W  = 8;
   localparam int MAT_W   = DIM_MAX * DIM_MAX * ELEM_W;
   localparam int DIM_W   = 3;
   localparam int IDX_W   = 5;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      LOAD_A,
      LOAD_B,
      ADD,
      OUT,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_DIM      = 2'd1;
   localparam logic [1:0] ERR_MISMATCH = 2'd2;
   localparam logic [1:0] ERR_ADD      = 2'd3;

   function automatic logic dim_ok(input logic [DIM_W-1:0] d);
      return (d != '0) && (int'(d) <= DIM_MAX);
   endfunction

endpackage

// File: rtl/add_unit.sv
// rtl/add_unit.sv - combinational element-wise adder over the packed m x n region
module AddUnit
   import matrix_pkg::*;
(
   input  logic [DIM_W-1:0] m,
   input  logic [DIM_W-1:0] n,
   input  logic [MAT_W-1:0] a,
   input  logic [MAT_W-1:0] b,
   output logic [MAT_W-1:0] a_plus_b,
   output logic             add_error
);

   // Elements outside the active m x n window are forced to zero.
   always_comb begin
      a_plus_b = '0;
      for (int i = 0; i < DIM_MAX; i++) begin
         for (int j = 0; j < DIM_MAX; j++) begin
            if (i < int'(m) && j < int'(n)) begin
               a_plus_b[(i*DIM_MAX+j)*ELEM_W +: ELEM_W] =
                  a[(i*DIM_MAX+j)*ELEM_W +: ELEM_W] + b[(i*DIM_MAX+j)*ELEM_W +: ELEM_W];
            end
         end
      end
   end

   assign add_error = !dim_ok(m) || !dim_ok(n);

endmodule

// File: rtl/mat_idx_counter.sv
// rtl/mat_idx_counter.sv - row-major row/col walker bounded by (m,n), wraps to (0,0) after the last element
module mat_idx_counter
   import matrix_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   input  logic [DIM_W-1:0] m,
   input  logic [DIM_W-1:0] n,
   output logic [DIM_W-1:0] row,
   output logic [DIM_W-1:0] col,
   output logic [IDX_W-1:0] idx,
   output logic             last
);

   logic col_end;

   assign col_end = (col == n - 3'd1);
   assign last    = col_end && (row == m - 3'd1);
   assign idx     = IDX_W'(row) * IDX_W'(DIM_MAX) + IDX_W'(col);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (col_end) begin
            col <= '0;
            row <= last ? '0 : row + 3'd1;
         end else begin
            col <= col + 3'd1;
         end
      end
   end

endmodule

// File: rtl/matrix_add_ctrl.sv
// rtl/matrix_add_ctrl.sv - loads A and B from the matrix store, adds them and streams the m x n sum
module matrix_add_ctrl
   import matrix_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DIM_W-1:0]  dimA_m,
   input  logic [DIM_W-1:0]  dimA_n,
   input  logic [DIM_W-1:0]  dimB_m,
   input  logic [DIM_W-1:0]  dimB_n,
   output logic              busy,
   output logic              rd_en,
   output logic              rd_sel,
   output logic [IDX_W-1:0]  rd_idx,
   input  logic [ELEM_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ELEM_W-1:0] out_data,
   output logic [DIM_W-1:0]  out_row,
   output logic [DIM_W-1:0]  out_col,
   output logic              out_last,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   state_t           state;
   logic [DIM_W-1:0] a_m, a_n, b_m, b_n;
   logic [MAT_W-1:0] buf_a, buf_b, res_buf, sum;
   logic             add_error;
   logic             pend, pend_sel;
   logic [IDX_W-1:0] pend_idx;
   logic [DIM_W-1:0] row, col;
   logic [IDX_W-1:0] idx;
   logic             last;
   logic             cnt_clear, cnt_inc, hs;

   assign hs        = out_valid && out_ready;
   assign cnt_clear = (state == CHECK);
   assign cnt_inc   = ((state == LOAD_A || state == LOAD_B) && rd_en) || (state == OUT && hs);

   // Address and result fields are only driven while their strobe is up.
   assign rd_idx   = rd_en ? idx : '0;
   assign out_data = out_valid ? res_buf[int'(idx)*ELEM_W +: ELEM_W] : '0;
   assign out_row  = out_valid ? row : '0;
   assign out_col  = out_valid ? col : '0;
   assign out_last = out_valid && last;

   mat_idx_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .m     (a_m),
      .n     (a_n),
      .row   (row),
      .col   (col),
      .idx   (idx),
      .last  (last)
   );

   AddUnit u_add (
      .m         (a_m),
      .n         (a_n),
      .a         (buf_a),
      .b         (buf_b),
      .a_plus_b  (sum),
      .add_error (add_error)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         a_m       <= '0;
         a_n       <= '0;
         b_m       <= '0;
         b_n       <= '0;
         buf_a     <= '0;
         buf_b     <= '0;
         res_buf   <= '0;
         pend      <= 1'b0;
         pend_sel  <= 1'b0;
         pend_idx  <= '0;
         busy      <= 1'b0;
         rd_en     <= 1'b0;
         rd_sel    <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         // Store data arrives one cycle after the strobe; remember where it goes.
         pend <= rd_en;
         if (rd_en) begin
            pend_sel <= rd_sel;
            pend_idx <= idx;
         end
         if (pend) begin
            if (pend_sel) buf_b[int'(pend_idx)*ELEM_W +: ELEM_W] <= rd_data;
            else          buf_a[int'(pend_idx)*ELEM_W +: ELEM_W] <= rd_data;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  a_m      <= dimA_m;
                  a_n      <= dimA_n;
                  b_m      <= dimB_m;
                  b_n      <= dimB_n;
                  err_code <= ERR_NONE;
                  busy     <= 1'b1;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (!dim_ok(a_m) || !dim_ok(a_n) || !dim_ok(b_m) || !dim_ok(b_n)) begin
                  err      <= 1'b1;
                  err_code <= ERR_DIM;
                  state    <= ERR;
               end else if (a_m != b_m || a_n != b_n) begin
                  err      <= 1'b1;
                  err_code <= ERR_MISMATCH;
                  state    <= ERR;
               end else begin
                  buf_a   <= '0;
                  buf_b   <= '0;
                  res_buf <= '0;
                  rd_en   <= 1'b1;
                  rd_sel  <= 1'b0;
                  state   <= LOAD_A;
               end
            end
            LOAD_A: begin
               if (rd_en) begin
                  if (last) rd_en <= 1'b0;
               end else begin
                  rd_en  <= 1'b1;
                  rd_sel <= 1'b1;
                  state  <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (rd_en) begin
                  if (last) rd_en <= 1'b0;
               end else begin
                  rd_sel <= 1'b0;
                  state  <= ADD;
               end
            end
            ADD: begin
               if (add_error) begin
                  err      <= 1'b1;
                  err_code <= ERR_ADD;
                  state    <= ERR;
               end else begin
                  res_buf   <= sum;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (hs && last) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            ERR: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
